instr_prefetch_queue: RTL and testbench
=======================================

# instr_prefetch_queue

Parametrised instruction register queue that replaces the single-entry instruction register between instruction memory and the decode stage. It buffers up to DEPTH fetched instruction words, each with its fetch PC, in FIFO order. Both sides use a valid/ready handshake, and a synchronous flush discards all buffered words on a branch or jump redirect. Decode sees the oldest word combinationally (show-ahead), so an empty queue adds one cycle of fetch-to-decode latency and a non-empty queue adds none.

## Interface
- DATA_W, 32, instruction word width
- PC_W, 32, fetch PC tag width
- DEPTH, 4, number of entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH+1), width of occupancy count
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- flush  input  1  discard all entries at next edge
- in_valid  input  1  fetch side presents a word
- in_data  input  DATA_W  fetched instruction
- in_pc  input  PC_W  PC of in_data
- in_ready  output  1  queue accepts a word this cycle
- out_valid  output  1  out_data/out_pc hold the oldest entry
- out_data  output  DATA_W  oldest instruction; 0 when out_valid=0
- out_pc  output  PC_W  PC of oldest instruction; 0 when out_valid=0
- out_ready  input  1  decode consumes the head this cycle
- count  output  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage is DEPTH entries of {in_pc, in_data}, with write pointer wr_ptr, read pointer rd_ptr (each log2(DEPTH) bits, natural wrap at DEPTH-1 → 0) and count register.
- in_ready = !flush && (count < DEPTH).
  - A full queue never accepts a word, even when a pop occurs in the same cycle. There is no pass-through.
- out_valid = (count != 0).
  - out_data and out_pc = entry[rd_ptr] when valid, else forced to 0.
- push = in_valid && in_ready: write entry[wr_ptr] and increment wr_ptr.
- pop = out_valid && out_ready && !flush: increment rd_ptr.
- count next value:
  - push only: +1
  - pop only: −1
  - both, or neither: unchanged
- flush=1 (and rst_n=1):
  - wr_ptr, rd_ptr and count are set to 0.
  - The push and pop in that cycle are suppressed.
  - Entry contents are not cleared.
- rst_n=0: same effect as flush, with priority over everything. It is valid mid-operation and discards all in-flight words.
- Entry storage has no reset. Outputs never expose it, because of the out_valid gating.
- No error state: in_valid while full is legal backpressure, and out_ready while empty is ignored.

## Timing
- Reset values (first edge with rst_n=0):
  - count=0
  - out_valid=0
  - out_data=0
  - out_pc=0
  - in_ready=1 (when flush=0)
- Latency:
  - A word pushed at edge N appears on out_data after edge N if the queue was empty. Otherwise it appears after all older entries are popped.
  - in_ready and out_valid are combinational on count and flush. There is no combinational path from in_valid to out_valid or from out_ready to in_ready.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- Boundaries:
  - count=DEPTH: in_ready=0, and a pop frees space visible in the next cycle.
  - count=0: a pop is ignored.
  - Pointer wrap DEPTH-1 → 0 is transparent.
  - flush together with push and pop: the result is an empty queue, and the pushed word is lost (fetch must re-issue).

## Test plan
- Reset/basic:
  - Stimulus: rst_n=0 for 2 cycles, then push 0x00000013 with pc 0x100.
  - Required response: during reset count=0, out_valid=0, out_data=0. One cycle after the push, out_valid=1, out_data=0x00000013, out_pc=0x100, count=1.
- Fill to full (DEPTH=4):
  - Stimulus: out_ready=0, push 5 consecutive words A0..A4.
  - Required response: A0..A3 accepted, count=4, in_ready=0 on the 5th cycle, A4 not stored. Then popping 4 times yields A0..A3 in order and count returns to 0.
- Simultaneous push/pop with wrap:
  - Stimulus: prefill 2 words, then hold in_valid=1 and out_ready=1 for 10 cycles.
  - Required response: count stays 2, the output sequence is strictly FIFO, and the pointers wrap at least twice with no lost or duplicated word.
- Full plus pop:
  - Stimulus: count=4, in_valid=1, out_ready=1 in the same cycle.
  - Required response: the pop occurs, the push is refused (in_ready=0), count=3 next cycle, and in_ready=1 next cycle.
- Flush:
  - Stimulus: count=3, then assert flush with in_valid=1 and out_ready=1.
  - Required response: in_ready=0 in that cycle. Next cycle count=0, out_valid=0, out_data=0. A subsequent push of 0xDEADBEEF/pc 0x200 appears as the head.
- Reset mid-operation:
  - Stimulus: count=2, rst_n=0 for 1 cycle while in_valid=1.
  - Required response: next cycle count=0, out_valid=0, and no entry from before reset is ever output.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between instruction memory and decode.
// Buffers up to DEPTH {pc, instruction} pairs in FIFO order. The head entry is
// shown combinationally to decode, and flush discards every buffered word on a
// redirect.
module instr_prefetch_queue #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // A full queue refuses words even if the head leaves this cycle; there is no pass-through
    assign in_ready  = !flush && (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    // Head presentation, forced to zero while empty so stale storage never leaks out
    always_comb begin
        out_data = '0;
        out_pc   = '0;
        if (out_valid) begin
            out_data = data_mem[rd_ptr];
            out_pc   = pc_mem[rd_ptr];
        end
    end

    // Entry storage carries no reset; only accepted words are written
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= in_data;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed self-checking bench for instr_prefetch_queue at DEPTH=4.
module tb_instr_prefetch_queue;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic              out_ready;
    logic [CNT_W-1:0]  count;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    instr_prefetch_queue #(
        .DATA_W(DATA_W),
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_pc    (in_pc),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_pc   (out_pc),
        .out_ready(out_ready),
        .count    (count)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive every input of the queue at once
    task automatic applyStimulus(input logic rn, input logic fl, input logic iv,
                                 input logic [31:0] d, input logic [31:0] p,
                                 input logic ordy);
        rst_n     = rn;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        in_pc     = p;
        out_ready = ordy;
        #1;
    endtask

    // Advance one rising edge and let outputs settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison of an observed value against a bench-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] wordA(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] wordB(input int i);
        return 32'hB000_0000 + 32'(i);
    endfunction

    initial begin
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset held for two edges
        tick();
        tick();
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_pc", 64'(out_pc), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

        // First push appears one edge later
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'h100, 1'b0);
        checkOutput("basic_in_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("basic_out_valid", 64'(out_valid), 64'd1);
        checkOutput("basic_out_data", 64'(out_data), 64'h13);
        checkOutput("basic_out_pc", 64'(out_pc), 64'h100);
        checkOutput("basic_count", 64'(count), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("basic_drain_count", 64'(count), 64'd0);

        // Fill to full with five offers, the fifth refused
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, wordA(i), 32'h1000 + 32'(4 * i), 1'b0);
            checkOutput($sformatf("fill_in_ready_%0d", i), 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
            tick();
        end
        checkOutput("full_count", 64'(count), 64'd4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_data_%0d", i), 64'(out_data), 64'(wordA(i)));
            checkOutput($sformatf("drain_pc_%0d", i), 64'(out_pc), 64'(32'h1000 + 32'(4 * i)));
            tick();
        end
        checkOutput("drain_count", 64'(count), 64'd0);
        checkOutput("drain_out_data", 64'(out_data), 64'd0);

        // Pop on an empty queue is ignored
        tick();
        checkOutput("empty_pop_count", 64'(count), 64'd0);
        checkOutput("empty_pop_valid", 64'(out_valid), 64'd0);

        // Prefill two words, then stream ten push+pop cycles across pointer wraps
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, wordB(i), 32'h2000 + 32'(i), 1'b0);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, wordB(k + 2), 32'h2000 + 32'(k + 2), 1'b1);
            checkOutput($sformatf("stream_data_%0d", k), 64'(out_data), 64'(wordB(k)));
            checkOutput($sformatf("stream_pc_%0d", k), 64'(out_pc), 64'(32'h2000 + 32'(k)));
            tick();
            checkOutput($sformatf("stream_count_%0d", k), 64'(count), 64'd2);
        end

        // Top up to full: B10, B11 queued, add B12, B13
        for (int i = 12; i < 14; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, wordB(i), 32'h2000 + 32'(i), 1'b0);
            tick();
        end
        checkOutput("refill_count", 64'(count), 64'd4);

        // Full plus pop: pop happens, push refused
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h7777_7777, 32'h777, 1'b1);
        checkOutput("fullpop_in_ready", 64'(in_ready), 64'd0);
        checkOutput("fullpop_head", 64'(out_data), 64'(wordB(10)));
        tick();
        checkOutput("fullpop_count", 64'(count), 64'd3);
        checkOutput("fullpop_in_ready_next", 64'(in_ready), 64'd1);
        checkOutput("fullpop_head_next", 64'(out_data), 64'(wordB(11)));

        // Flush with push and pop both requested at count=3
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h5555_5555, 32'h555, 1'b1);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        checkOutput("flush_count", 64'(count), 64'd0);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_out_data", 64'(out_data), 64'd0);
        checkOutput("flush_out_pc", 64'(out_pc), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h200, 1'b0);
        tick();
        checkOutput("postflush_data", 64'(out_data), 64'hDEAD_BEEF);
        checkOutput("postflush_pc", 64'(out_pc), 64'h200);
        checkOutput("postflush_count", 64'(count), 64'd1);

        // Reset mid-operation at count=2 while a word is offered
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hE000_0000, 32'h204, 1'b0);
        tick();
        checkOutput("premid_count", 64'(count), 64'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hF000_0000, 32'h208, 1'b0);
        tick();
        checkOutput("midrst_count", 64'(count), 64'd0);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_out_data", 64'(out_data), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("postrst_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h300, 1'b0);
        tick();
        checkOutput("postrst_head", 64'(out_data), 64'h1234_5678);
        checkOutput("postrst_pc", 64'(out_pc), 64'h300);
        checkOutput("postrst_count", 64'(count), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("final_count", 64'(count), 64'd0);
        checkOutput("final_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d comparisons with %0d failing", total_cnt, fail_cnt);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
